// File: rtl/ksk_buffer_ctrl.sv
// Write/read sequencer for the 12-URAM key-switching-key buffer: fills one stage from a
// beat stream and sweeps a stage's read addresses, guarding stages with a valid bitmap.
module ksk_buffer_ctrl #(
    parameter int DATA_WIDTH = 39,
    parameter int URAM_DELAY = 3,
    parameter int NUM_STAGE  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load_start,
    input  logic [3:0]              i_load_stage,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_WIDTH-1:0] s_data,
    output logic                    o_load_busy,
    output logic                    o_load_done,
    output logic                    o_load_err,
    input  logic                    i_rd_start,
    input  logic [3:0]              i_rd_stage,
    output logic                    o_rd_busy,
    output logic                    o_rd_valid,
    output logic                    o_rd_last,
    output logic                    o_rd_err,
    output logic [NUM_STAGE-1:0]    o_stage_valid,
    output logic                    o_ksk_wr_en,
    output logic [3:0]              o_ksk_wr_stage,
    output logic [3:0]              o_ksk_wr_index,
    output logic [8:0]              o_ksk_wr_addr,
    output logic [8*DATA_WIDTH-1:0] o_ksk_wr_data,
    output logic [3:0]              o_ksk_rd_stage,
    output logic [11:0]             o_ksk_rd_addr,
    output logic                    o_dbg_w_state,
    output logic [1:0]              o_dbg_r_state
);
    localparam int DCW = (URAM_DELAY > 1) ? $clog2(URAM_DELAY) : 1;

    typedef enum logic {W_IDLE, W_LOAD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} r_state_t;

    w_state_t                r_w_state, w_w_next;
    r_state_t                r_r_state, w_r_next;
    logic [3:0]              r_ld_stage;
    logic [3:0]              r_idx;
    logic [8:0]              r_addr;
    logic                    r_wr_en, r_load_done, r_load_err;
    logic [3:0]              r_wr_stage, r_wr_index;
    logic [8:0]              r_wr_addr;
    logic [8*DATA_WIDTH-1:0] r_wr_data;
    logic [NUM_STAGE-1:0]    r_stage_valid;
    logic [3:0]              r_rd_stage;
    logic [11:0]             r_rd_addr;
    logic                    r_rd_err;
    logic [DCW-1:0]          r_drain;
    logic [URAM_DELAY-1:0]   r_vld_sr, r_last_sr;
    logic                    w_ld_acc, w_rd_acc, w_beat, w_last_beat, w_issue;
    logic                    w_load_busy, w_rd_busy;

    // Handshake: s_ready is high for the whole of W_LOAD and depends only on state;
    // a beat transfers on every rising edge where s_valid && s_ready.
    assign w_load_busy = (r_w_state == W_LOAD);
    assign w_rd_busy   = (r_r_state != R_IDLE);
    assign w_beat      = s_valid && w_load_busy;
    assign w_last_beat = (r_idx == 4'd11) && (r_addr == 9'd511);
    assign w_issue     = (r_r_state == R_RUN);

    always_comb begin
        w_w_next = r_w_state;
        w_ld_acc = 1'b0;
        case (r_w_state)
            W_IDLE: if (i_load_start && !(w_rd_busy && r_rd_stage == i_load_stage)) begin
                w_ld_acc = 1'b1;
                w_w_next = W_LOAD;
            end
            W_LOAD: if (w_beat && w_last_beat) w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    // A same-cycle load of the same stage takes priority over the read.
    always_comb begin
        w_r_next = r_r_state;
        w_rd_acc = 1'b0;
        case (r_r_state)
            R_IDLE: if (i_rd_start && r_stage_valid[i_rd_stage]
                        && !(w_load_busy && r_ld_stage == i_rd_stage)
                        && !(w_ld_acc && i_load_stage == i_rd_stage)) begin
                w_rd_acc = 1'b1;
                w_r_next = R_RUN;
            end
            R_RUN:   if (r_rd_addr == 12'd4095) w_r_next = R_DRAIN;
            R_DRAIN: if (r_drain == DCW'(URAM_DELAY - 1)) w_r_next = R_IDLE;
            default: w_r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_state     <= W_IDLE;
            r_ld_stage    <= '0;
            r_idx         <= '0;
            r_addr        <= '0;
            r_wr_en       <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
            r_wr_stage    <= '0;
            r_wr_index    <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_stage_valid <= '0;
        end else begin
            r_w_state   <= w_w_next;
            r_wr_en     <= w_beat;
            r_load_done <= w_beat && w_last_beat;
            r_load_err  <= i_load_start && !w_ld_acc;
            if (w_ld_acc) begin
                r_ld_stage                  <= i_load_stage;
                r_idx                       <= '0;
                r_addr                      <= '0;
                r_stage_valid[i_load_stage] <= 1'b0;
            end
            if (w_beat) begin
                r_wr_stage <= r_ld_stage;
                r_wr_index <= r_idx;
                r_wr_addr  <= r_addr;
                r_wr_data  <= s_data;
                if (r_addr == 9'd511) begin
                    r_addr <= '0;
                    r_idx  <= r_idx + 4'd1;
                end else begin
                    r_addr <= r_addr + 9'd1;
                end
                if (w_last_beat) r_stage_valid[r_ld_stage] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_state  <= R_IDLE;
            r_rd_stage <= '0;
            r_rd_addr  <= '0;
            r_rd_err   <= 1'b0;
            r_drain    <= '0;
            r_vld_sr   <= '0;
            r_last_sr  <= '0;
        end else begin
            r_r_state <= w_r_next;
            r_rd_err  <= i_rd_start && !w_rd_acc;
            if (w_rd_acc) begin
                r_rd_stage <= i_rd_stage;
                r_rd_addr  <= '0;
            end else if (w_issue && r_rd_addr != 12'd4095) begin
                r_rd_addr <= r_rd_addr + 12'd1;
            end
            if (r_r_state == R_DRAIN) r_drain <= r_drain + DCW'(1);
            else                      r_drain <= '0;
            // Valid/last ride a delay line matching the buffer read latency.
            r_vld_sr[0]  <= w_issue;
            r_last_sr[0] <= w_issue && (r_rd_addr == 12'd4095);
            for (int k = 1; k < URAM_DELAY; k++) begin
                r_vld_sr[k]  <= r_vld_sr[k-1];
                r_last_sr[k] <= r_last_sr[k-1];
            end
        end
    end

    assign s_ready        = w_load_busy;
    assign o_load_busy    = w_load_busy;
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_rd_busy      = w_rd_busy;
    assign o_rd_valid     = r_vld_sr[URAM_DELAY-1];
    assign o_rd_last      = r_last_sr[URAM_DELAY-1];
    assign o_rd_err       = r_rd_err;
    assign o_stage_valid  = r_stage_valid;
    assign o_ksk_wr_en    = r_wr_en;
    assign o_ksk_wr_stage = r_wr_stage;
    assign o_ksk_wr_index = r_wr_index;
    assign o_ksk_wr_addr  = r_wr_addr;
    assign o_ksk_wr_data  = r_wr_data;
    assign o_ksk_rd_stage = r_rd_stage;
    assign o_ksk_rd_addr  = r_rd_addr;
    assign o_dbg_w_state  = r_w_state;
    assign o_dbg_r_state  = r_r_state;
endmodule
